banco_registros: RTL and testbench
==================================

BANCO_REGISTROS -- requirements
Module: banco_registros

Interface
REQ-001 Parameter ANCHO, default 32: data word width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers; address width is log2(NREG) (5 at default).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 esc_reg  input  1  write enable from the write-back write-enable mux; 1 = write this cycle.
REQ-006 dir_esc  input  5  write-back destination register.
REQ-007 dato_esc  input  ANCHO  write-back data.
REQ-008 lee_a  input  5  read port A source register (rs).
REQ-009 lee_b  input  5  read port B source register (rt).
REQ-010 emite_carga  input  1  decode stage issues a load; its destination becomes pending.
REQ-011 dir_carga  input  5  destination register of the issuing load.
REQ-012 dato_a  output  ANCHO  registered read data, port A.
REQ-013 dato_b  output  ANCHO  registered read data, port B.
REQ-014 detener  output  1  combinational stall request to decode; 1 = a source is pending.

Function
REQ-015 Storage: NREG x ANCHO array; register 0 reads as 0 and is never written.
REQ-016 Write: on rising clk with esc_reg=1 and dir_esc!=0, reg[dir_esc] <= dato_esc; otherwise array unchanged.
REQ-017 Read latency: exactly 1 cycle; dato_a/dato_b update every rising edge from the lee_a/lee_b values sampled at that edge.
REQ-018 Read value: 0 if the address is 0; else dato_esc if esc_reg=1 and dir_esc equals the address (write-through bypass); else the stored reg[address].
REQ-019 Scoreboard: NREG-bit pending vector pend; pend[0] permanently 0.
REQ-020 Set: on rising clk, emite_carga=1, dir_carga!=0 and detener=0 -> pend[dir_carga] <= 1.
REQ-021 Clear: on rising clk, esc_reg=1 and dir_esc!=0 -> pend[dir_esc] <= 0.
REQ-022 Simultaneous set and clear on the same index: set wins; pend stays 1 (new load outstanding).
REQ-023 detener = (pend[lee_a] and not clearing lee_a this cycle) or (the same for lee_b), where "clearing" means esc_reg=1 and dir_esc equals the address; address 0 never stalls.
REQ-024 While detener=1, emite_carga is ignored; dato_a/dato_b still update per REQ-017.
REQ-025 A write to a register with pend=0 is legal and only updates data.

Reset
REQ-026 On rst_n=0, immediately and regardless of clk: all array entries, pend, dato_a and dato_b SHALL be 0.
REQ-027 detener SHALL be 0 during reset, because pend=0.
REQ-028 Deassertion SHALL take effect at the first rising clk after rst_n=1; a write or load issue arriving together with the reset is discarded.

Structure
REQ-029 ANCHO, NREG, the address width and the register-0 index constant SHALL live in the shared pipeline package.
REQ-030 The scoreboard SHALL be one sub-module, marcador_pend (set/clear/query logic), instantiated once.

Verification
REQ-031 Reset -> read r1..r31 on both ports -> all dato_a/dato_b = 0 and detener = 0.
REQ-032 Write r5=0xDEADBEEF -> next cycle lee_a=5 -> one cycle later dato_a=0xDEADBEEF; write r0=0x1234 -> reading r0 gives 0.
REQ-033 Same-cycle write r7=0xA5A5A5A5 while lee_b=7 -> dato_b=0xA5A5A5A5 at the next edge (bypass).
REQ-034 Issue load r3; next cycle lee_a=3 -> detener=1; emite_carga for r4 during the stall -> pend[4] stays 0; write-back esc_reg=1, dir_esc=3 -> detener=0 in that same cycle.
REQ-035 Issue load r9 in the same cycle as write-back to r9 -> pend[9]=1 afterwards; then a write to r9 with emite_carga=0 -> pend[9]=0.
REQ-036 rst_n pulsed low mid-stall (pend[3]=1, r5 nonzero) -> detener=0, r5=0 and dato outputs = 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/banco_registros_pkg.sv
// Shared pipeline constants for the register file and load scoreboard.
package banco_registros_pkg;

  localparam int unsigned ANCHO     = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned ANCHO_DIR = $clog2(NREG);

  // Index of the hard-wired zero register
  localparam logic [ANCHO_DIR-1:0] REG_CERO = '0;

endpackage

// File: rtl/banco_registros_marcador_pend.sv
// Load scoreboard: tracks registers whose load result is still outstanding
// and raises a stall when a source operand is one of them.
module marcador_pend
  import banco_registros_pkg::*;
#(
  parameter int unsigned NREG_P = banco_registros_pkg::NREG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       emite_carga,
  input  logic [$clog2(NREG_P)-1:0]  dir_carga,
  input  logic                       esc_reg,
  input  logic [$clog2(NREG_P)-1:0]  dir_esc,
  input  logic [$clog2(NREG_P)-1:0]  lee_a,
  input  logic [$clog2(NREG_P)-1:0]  lee_b,
  output logic                       detener
);

  localparam int unsigned DIR_W = $clog2(NREG_P);

  logic [NREG_P-1:0] pend_q;
  logic [NREG_P-1:0] pend_d;
  logic              limpia;
  logic              marca;
  logic              espera_a;
  logic              espera_b;

  // A source stalls only if pending and not being written back this cycle
  always_comb begin
    limpia   = esc_reg && (dir_esc != DIR_W'(REG_CERO));
    espera_a = pend_q[lee_a] && !(esc_reg && (dir_esc == lee_a));
    espera_b = pend_q[lee_b] && !(esc_reg && (dir_esc == lee_b));
    detener  = espera_a || espera_b;
    marca    = emite_carga && (dir_carga != DIR_W'(REG_CERO)) && !detener;
  end

  // Next pending vector: clear first so a same-index new load wins
  always_comb begin
    pend_d = pend_q;
    if (limpia) pend_d[dir_esc] = 1'b0;
    if (marca)  pend_d[dir_carga] = 1'b1;
    pend_d[REG_CERO] = 1'b0;
  end

  // Pending vector register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

endmodule

// File: rtl/banco_registros.sv
// Two-read, one-write register file with write-through bypass, registered
// read outputs and a load-pending scoreboard that stalls decode.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int unsigned ANCHO = banco_registros_pkg::ANCHO,
  parameter int unsigned NREG  = banco_registros_pkg::NREG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     esc_reg,
  input  logic [$clog2(NREG)-1:0]  dir_esc,
  input  logic [ANCHO-1:0]         dato_esc,
  input  logic [$clog2(NREG)-1:0]  lee_a,
  input  logic [$clog2(NREG)-1:0]  lee_b,
  input  logic                     emite_carga,
  input  logic [$clog2(NREG)-1:0]  dir_carga,
  output logic [ANCHO-1:0]         dato_a,
  output logic [ANCHO-1:0]         dato_b,
  output logic                     detener
);

  localparam int unsigned DIR_W = $clog2(NREG);

  logic [ANCHO-1:0] regs_q [NREG];
  logic [ANCHO-1:0] regs_d [NREG];
  logic [ANCHO-1:0] dato_a_q;
  logic [ANCHO-1:0] dato_a_d;
  logic [ANCHO-1:0] dato_b_q;
  logic [ANCHO-1:0] dato_b_d;

  // Array update; register 0 is never written
  always_comb begin
    regs_d = regs_q;
    if (esc_reg && (dir_esc != DIR_W'(REG_CERO))) regs_d[dir_esc] = dato_esc;
    regs_d[REG_CERO] = '0;
  end

  // Read mux with zero register and same-cycle write-through bypass
  always_comb begin
    dato_a_d = regs_q[lee_a];
    dato_b_d = regs_q[lee_b];
    if (esc_reg && (dir_esc == lee_a)) dato_a_d = dato_esc;
    if (esc_reg && (dir_esc == lee_b)) dato_b_d = dato_esc;
    if (lee_a == DIR_W'(REG_CERO)) dato_a_d = '0;
    if (lee_b == DIR_W'(REG_CERO)) dato_b_d = '0;
  end

  // Storage and registered read ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
    end else begin
      regs_q   <= regs_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
    end
  end

  assign dato_a = dato_a_q;
  assign dato_b = dato_b_q;

  marcador_pend #(
    .NREG_P (NREG)
  ) u_marcador_pend (
    .clk         (clk),
    .rst_n       (rst_n),
    .emite_carga (emite_carga),
    .dir_carga   (dir_carga),
    .esc_reg     (esc_reg),
    .dir_esc     (dir_esc),
    .lee_a       (lee_a),
    .lee_b       (lee_b),
    .detener     (detener)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Directed self-checking bench for banco_registros.
module tb_banco_registros;

  logic        clk;
  logic        rst_n;
  logic        esc_reg;
  logic [4:0]  dir_esc;
  logic [31:0] dato_esc;
  logic [4:0]  lee_a;
  logic [4:0]  lee_b;
  logic        emite_carga;
  logic [4:0]  dir_carga;
  logic [31:0] dato_a;
  logic [31:0] dato_b;
  logic        detener;

  int errors = 0;
  int checks = 0;

  banco_registros dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .esc_reg     (esc_reg),
    .dir_esc     (dir_esc),
    .dato_esc    (dato_esc),
    .lee_a       (lee_a),
    .lee_b       (lee_b),
    .emite_carga (emite_carga),
    .dir_carga   (dir_carga),
    .dato_a      (dato_a),
    .dato_b      (dato_b),
    .detener     (detener)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; esc_reg = 1'b0; dir_esc = '0; dato_esc = '0;
    lee_a = '0; lee_b = '0; emite_carga = 1'b0; dir_carga = '0;
    #3;
    chk("rst_dato_a", dato_a, 32'h0);
    chk("rst_dato_b", dato_b, 32'h0);
    chk("rst_detener", {31'h0, detener}, 32'h0);
    step(); step();
    rst_n = 1'b1;

    // All registers read zero after reset
    for (int i = 1; i < 32; i++) begin
      lee_a = 5'(i); lee_b = 5'(32 - i);
      step();
      chk("init_a", dato_a, 32'h0);
      chk("init_b", dato_b, 32'h0);
      chk("init_det", {31'h0, detener}, 32'h0);
    end

    // Write r5 then read it back
    lee_a = 5'd0; lee_b = 5'd0;
    esc_reg = 1'b1; dir_esc = 5'd5; dato_esc = 32'hDEADBEEF;
    step();
    chk("r0_read", dato_a, 32'h0);
    esc_reg = 1'b0; lee_a = 5'd5;
    step();
    chk("r5_read", dato_a, 32'hDEADBEEF);

    // Writes to r0 are dropped, including the bypass path
    esc_reg = 1'b1; dir_esc = 5'd0; dato_esc = 32'h1234; lee_a = 5'd0;
    step();
    chk("r0_bypass", dato_a, 32'h0);
    esc_reg = 1'b0;
    step();
    chk("r0_stored", dato_a, 32'h0);

    // Same-cycle write-through on port B
    esc_reg = 1'b1; dir_esc = 5'd7; dato_esc = 32'hA5A5A5A5; lee_b = 5'd7;
    step();
    chk("r7_bypass", dato_b, 32'hA5A5A5A5);
    esc_reg = 1'b0; dato_esc = 32'h0;
    step();
    chk("r7_stored", dato_b, 32'hA5A5A5A5);

    // Load r3, stall on it, ignored load r4, clear by write-back
    lee_a = 5'd0; lee_b = 5'd0;
    emite_carga = 1'b1; dir_carga = 5'd3;
    #1 chk("ld3_nostall", {31'h0, detener}, 32'h0);
    step();
    emite_carga = 1'b0; lee_a = 5'd3;
    #1 chk("ld3_stall", {31'h0, detener}, 32'h1);
    emite_carga = 1'b1; dir_carga = 5'd4;
    step();
    emite_carga = 1'b0;
    chk("ld3_stall_hold", {31'h0, detener}, 32'h1);
    esc_reg = 1'b1; dir_esc = 5'd3; dato_esc = 32'h0000_0033;
    #1 chk("wb3_release", {31'h0, detener}, 32'h0);
    step();
    esc_reg = 1'b0;
    chk("wb3_data", dato_a, 32'h0000_0033);
    #1 chk("pend3_clear", {31'h0, detener}, 32'h0);
    lee_a = 5'd4;
    #1 chk("pend4_clear", {31'h0, detener}, 32'h0);

    // Set wins over clear on the same index
    lee_a = 5'd0;
    emite_carga = 1'b1; dir_carga = 5'd9;
    esc_reg = 1'b1; dir_esc = 5'd9; dato_esc = 32'h99;
    step();
    emite_carga = 1'b0; esc_reg = 1'b0; lee_b = 5'd9;
    #1 chk("pend9_set", {31'h0, detener}, 32'h1);
    esc_reg = 1'b1; dato_esc = 32'h999;
    #1 chk("wb9_release", {31'h0, detener}, 32'h0);
    step();
    esc_reg = 1'b0;
    #1 chk("pend9_clear", {31'h0, detener}, 32'h0);
    chk("wb9_data", dato_b, 32'h999);

    // Asynchronous reset in the middle of a stall
    lee_b = 5'd0;
    emite_carga = 1'b1; dir_carga = 5'd3;
    step();
    emite_carga = 1'b0; lee_a = 5'd3; lee_b = 5'd5;
    #1 chk("stall_pre", {31'h0, detener}, 32'h1);
    step();
    chk("r5_pre", dato_b, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_det", {31'h0, detener}, 32'h0);
    chk("arst_a", dato_a, 32'h0);
    chk("arst_b", dato_b, 32'h0);
    // Activity during reset is discarded
    emite_carga = 1'b1; dir_carga = 5'd3;
    esc_reg = 1'b1; dir_esc = 5'd6; dato_esc = 32'h6666_6666;
    step();
    chk("arst_hold_b", dato_b, 32'h0);
    emite_carga = 1'b0; esc_reg = 1'b0; dato_esc = 32'h0;
    rst_n = 1'b1;
    #1 chk("post_det3", {31'h0, detener}, 32'h0);
    step();
    chk("post_r5", dato_b, 32'h0);
    lee_a = 5'd6; lee_b = 5'd7;
    step();
    chk("post_r6", dato_a, 32'h0);
    chk("post_r7", dato_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
